// File: rtl/ssha512_seq_pkg.sv
// ssha512_pkg: shared definitions for the SHA-512 sigma/Sum sequencer.
//   - request op encoding (2 bits, fully decoded)
//   - sequencer state enum (IDLE/LO/HI/RSP, or IDLE/CALC/RSP when
//     SSHA512_SEQ_DUAL_ALU_EN is defined)
//   - one-hot ALU select encoding and the op -> half-select helpers
package ssha512_pkg;

  localparam logic [1:0] SSHA512_OP_SIG0 = 2'd0;
  localparam logic [1:0] SSHA512_OP_SIG1 = 2'd1;
  localparam logic [1:0] SSHA512_OP_SUM0 = 2'd2;
  localparam logic [1:0] SSHA512_OP_SUM1 = 2'd3;

`ifdef SSHA512_SEQ_DUAL_ALU_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  // State entered on an accepted request.
  localparam state_e ST_FIRST = ST_CALC;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RSP  = 2'd3
  } state_e;

  localparam state_e ST_FIRST = ST_LO;
`endif

  // One-hot select for the 32-bit scalar datapath.
  typedef enum logic [5:0] {
    ALU_SIG0L = 6'b000001,
    ALU_SIG0H = 6'b000010,
    ALU_SIG1L = 6'b000100,
    ALU_SIG1H = 6'b001000,
    ALU_SUM0R = 6'b010000,
    ALU_SUM1R = 6'b100000
  } alu_sel_e;

  // Low-half select: used with rs1 = operand[31:0], rs2 = operand[63:32].
  function automatic alu_sel_e lo_sel(input logic [1:0] op);
    case (op)
      SSHA512_OP_SIG0: lo_sel = ALU_SIG0L;
      SSHA512_OP_SIG1: lo_sel = ALU_SIG1L;
      SSHA512_OP_SUM0: lo_sel = ALU_SUM0R;
      default:         lo_sel = ALU_SUM1R;
    endcase
  endfunction

  // High-half select: used with rs1 = operand[63:32], rs2 = operand[31:0].
  // Sum0/Sum1 are pure rotates, so the same op serves both halves once the
  // operand halves are swapped.
  function automatic alu_sel_e hi_sel(input logic [1:0] op);
    case (op)
      SSHA512_OP_SIG0: hi_sel = ALU_SIG0H;
      SSHA512_OP_SIG1: hi_sel = ALU_SIG1H;
      SSHA512_OP_SUM0: hi_sel = ALU_SUM0R;
      default:         hi_sel = ALU_SUM1R;
    endcase
  endfunction

endpackage

// File: rtl/ssha512_seq_if.sv
// ssha512_seq_if: request/response handshake bundle of the sequencer.
//   req_valid/req_ready/req_op/req_lo/req_hi : request channel
//   flush                                     : abandon in-flight work
//   rsp_valid/rsp_ready/rsp_lo/rsp_hi         : response channel
//   busy                                      : sequencer not idle
// modport master = requester side, modport slave = sequencer side.
interface ssha512_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_lo;
  logic [31:0] req_hi;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_lo;
  logic [31:0] rsp_hi;
  logic        busy;

  modport master (
    output req_valid, req_op, req_lo, req_hi, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_lo, rsp_hi, busy
  );

  modport slave (
    input  req_valid, req_op, req_lo, req_hi, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_lo, rsp_hi, busy
  );
endinterface

// File: rtl/ssha512_seq_alu.sv
// ssha512_alu: combinational 32-bit scalar SHA-512 half-word datapath.
//   rs1_i    [31:0] : "own" half of the 64-bit operand
//   rs2_i    [31:0] : other half of the 64-bit operand
//   sel_i    [5:0]  : one-hot op select (alu_sel_e order, bit0 = sig0l)
//   result_o [31:0] : selected function, 0 if no select bit is set
// All shifts are 32-bit logical shifts; terms combine with XOR only.
module ssha512_alu
  import ssha512_pkg::*;
(
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [5:0]  sel_i,
  output logic [31:0] result_o
);

  logic [31:0] sig0h, sig0l, sig1h, sig1l, sum0r, sum1r;

  // The "h" forms omit the term from the 64-bit logical shift (shr7/shr6),
  // which contributes nothing from the low word into the high word.
  assign sig0h = (rs1_i >> 1) ^ (rs1_i >> 7) ^ (rs1_i >> 8) ^
                 (rs2_i << 31) ^ (rs2_i << 24);
  assign sig0l = sig0h ^ (rs2_i << 25);
  assign sig1h = (rs1_i << 3) ^ (rs1_i >> 6) ^ (rs1_i >> 19) ^
                 (rs2_i >> 29) ^ (rs2_i << 13);
  assign sig1l = sig1h ^ (rs2_i << 26);
  assign sum0r = (rs1_i << 25) ^ (rs1_i << 30) ^ (rs1_i >> 28) ^
                 (rs2_i >> 7) ^ (rs2_i >> 2) ^ (rs2_i << 4);
  assign sum1r = (rs1_i << 23) ^ (rs1_i >> 14) ^ (rs1_i >> 18) ^
                 (rs2_i >> 9) ^ (rs2_i << 18) ^ (rs2_i << 14);

  assign result_o = ({32{sel_i[0]}} & sig0l) |
                    ({32{sel_i[1]}} & sig0h) |
                    ({32{sel_i[2]}} & sig1l) |
                    ({32{sel_i[3]}} & sig1h) |
                    ({32{sel_i[4]}} & sum0r) |
                    ({32{sel_i[5]}} & sum1r);

endmodule

// File: rtl/ssha512_seq.sv
// ssha512_seq: valid/ready sequencer for the 64-bit SHA-512 sigma0, sigma1,
// Sum0 and Sum1 functions built on the 32-bit scalar datapath.
//   g_clk    : core clock
//   g_resetn : asynchronous active-low reset
//   bus      : ssha512_seq_if.slave (request, flush, response, busy)
// Build option SSHA512_SEQ_DUAL_ALU_EN: second ALU computes the high half in
// the same cycle as the low half (2-cycle latency instead of 3).
//
// state | meaning
// IDLE  | waiting for a request, req_ready high unless flush
// LO    | low result word computed and registered (single-ALU build)
// HI    | high result word computed and registered (single-ALU build)
// CALC  | both result words computed and registered (dual-ALU build)
// RSP   | result held with rsp_valid until rsp_ready or flush
module ssha512_seq
  import ssha512_pkg::*;
(
  input  logic         g_clk,
  input  logic         g_resetn,
  ssha512_seq_if.slave bus
);

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] rsp_lo_q, rsp_lo_d;
  logic [31:0] rsp_hi_q, rsp_hi_d;
  logic        req_ready;
  logic        accept;

  // flush masks the request side so a same-cycle request is simply ignored.
  assign req_ready = ~bus.flush &
                     ((state_q == ST_IDLE) | ((state_q == ST_RSP) & bus.rsp_ready));
  assign accept    = bus.req_valid & req_ready;

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state_q == ST_RSP);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.rsp_lo    = rsp_lo_q;
  assign bus.rsp_hi    = rsp_hi_q;

`ifdef SSHA512_SEQ_DUAL_ALU_EN
  logic [31:0] res_lo, res_hi;
  logic [5:0]  sel_lo, sel_hi;

  assign sel_lo = lo_sel(op_q);
  assign sel_hi = hi_sel(op_q);

  ssha512_alu u_alu_lo (
    .rs1_i    (lo_q),
    .rs2_i    (hi_q),
    .sel_i    (sel_lo),
    .result_o (res_lo)
  );

  ssha512_alu u_alu_hi (
    .rs1_i    (hi_q),
    .rs2_i    (lo_q),
    .sel_i    (sel_hi),
    .result_o (res_hi)
  );
`else
  logic [31:0] alu_rs1, alu_rs2, alu_res;
  logic [5:0]  alu_sel;

  // Shared ALU: operand halves swap between the LO and HI passes.
  always_comb begin
    alu_rs1 = hi_q;
    alu_rs2 = lo_q;
    alu_sel = hi_sel(op_q);
    if (state_q == ST_LO) begin
      alu_rs1 = lo_q;
      alu_rs2 = hi_q;
      alu_sel = lo_sel(op_q);
    end
  end

  ssha512_alu u_alu (
    .rs1_i    (alu_rs1),
    .rs2_i    (alu_rs2),
    .sel_i    (alu_sel),
    .result_o (alu_res)
  );
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    rsp_lo_d = rsp_lo_q;
    rsp_hi_d = rsp_hi_q;

    if (accept) begin
      op_d = bus.req_op;
      lo_d = bus.req_lo;
      hi_d = bus.req_hi;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_FIRST;
      end
`ifdef SSHA512_SEQ_DUAL_ALU_EN
      ST_CALC: begin
        rsp_lo_d = res_lo;
        rsp_hi_d = res_hi;
        state_d  = ST_RSP;
      end
`else
      ST_LO: begin
        rsp_lo_d = alu_res;
        state_d  = ST_HI;
      end
      ST_HI: begin
        rsp_hi_d = alu_res;
        state_d  = ST_RSP;
      end
`endif
      ST_RSP: begin
        if (bus.rsp_ready) state_d = accept ? ST_FIRST : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Result registers keep their contents across a flush.
    if (bus.flush) state_d = ST_IDLE;
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      rsp_lo_q <= '0;
      rsp_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      rsp_lo_q <= rsp_lo_d;
      rsp_hi_q <= rsp_hi_d;
    end
  end

endmodule

// File: tb/tb_ssha512_seq.sv
// Self-checking bench for ssha512_seq: directed vectors, random operands
// against a 64-bit rotate/shift reference, backpressure, flush, reset and
// streaming throughput.
module tb_ssha512_seq;

`ifdef SSHA512_SEQ_DUAL_ALU_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;

  ssha512_seq_if bus ();

  ssha512_seq dut (
    .g_clk    (clk),
    .g_resetn (rstn),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] ref_fn(input logic [1:0] op, input logic [63:0] x);
    case (op)
      2'd0:    return ror64(x, 1) ^ ror64(x, 8) ^ (x >> 7);
      2'd1:    return ror64(x, 19) ^ ror64(x, 61) ^ (x >> 6);
      2'd2:    return ror64(x, 28) ^ ror64(x, 34) ^ ror64(x, 39);
      default: return ror64(x, 14) ^ ror64(x, 18) ^ ror64(x, 41);
    endcase
  endfunction

  task automatic drive_req(input logic [1:0] op, input logic [63:0] x);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_lo    = x[31:0];
    bus.req_hi    = x[63:32];
  endtask

  // Present a request, wait for accept, then count cycles until rsp_valid.
  task automatic issue(input logic [1:0] op, input logic [63:0] x, output int lat);
    int n;
    drive_req(op, x);
    #1;
    n = 0;
    while (!bus.req_ready && n < 10) begin
      tick();
      n++;
    end
    if (n >= 10) chk("accept_timeout", 64'(n), 64'(0));
    tick();
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [63:0] x,
                        input logic [63:0] exp);
    int lat;
    issue(op, x, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(LAT));
    chk(tag, {bus.rsp_hi, bus.rsp_lo}, exp);
    consume();
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [63:0] x;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [63:0] held;
    logic [63:0] x;
    logic [1:0]  op;
    int          lat;
    int          got;
    int          idx;
    int          cyc;
    int          last;
    bit          acc;

    n_checks = 0;
    n_errors = 0;

    // Hand-derived expectations (single set bits / all-ones make the
    // rotate positions easy to place by hand).
    vecs[0] = '{2'd0, 64'h0000_0000_0000_0001, 64'h8100_0000_0000_0000};
    vecs[1] = '{2'd1, 64'h0000_0000_0000_0001, 64'h0000_2000_0000_0008};
    vecs[2] = '{2'd2, 64'h0000_0000_0000_0001, 64'h0000_0010_4200_0000};
    vecs[3] = '{2'd3, 64'h0000_0000_0000_0001, 64'h0004_4000_0080_0000};
    vecs[4] = '{2'd0, 64'h0000_0001_0000_0000, 64'h0000_0000_8300_0000};
    vecs[5] = '{2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h03FF_FFFF_FFFF_FFFF};
    vecs[6] = '{2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[7] = '{2'd3, 64'h8000_0000_0000_0000, 64'h0002_2000_0040_0000};

    rstn          = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'd0;
    bus.req_lo    = '0;
    bus.req_hi    = '0;
    bus.flush     = 1'b0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();

    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_req_ready", 64'(bus.req_ready), 64'(1));
    chk("rst_rsp", {bus.rsp_hi, bus.rsp_lo}, 64'h0);

    // Directed vectors.
    for (int i = 0; i < 8; i++) run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].x, vecs[i].exp);

    // Random operands, all ops.
    for (int i = 0; i < 1000; i++) begin
      x  = {$urandom, $urandom};
      op = 2'($urandom_range(3, 0));
      issue(op, x, lat);
      chk("rand_lat", 64'(lat), 64'(LAT));
      chk("rand_res", {bus.rsp_hi, bus.rsp_lo}, ref_fn(op, x));
      consume();
    end

    // Backpressure: result held, no accept while rsp_ready low.
    issue(2'd2, 64'h0123_4567_89AB_CDEF, lat);
    held = ref_fn(2'd2, 64'h0123_4567_89AB_CDEF);
    chk("bp_first", {bus.rsp_hi, bus.rsp_lo}, held);
    drive_req(2'd1, 64'hDEAD_BEEF_0BAD_F00D);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_ready", 64'(bus.req_ready), 64'(0));
      chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'(1));
      chk("bp_stable", {bus.rsp_hi, bus.rsp_lo}, held);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_same_cycle_ready", 64'(bus.req_ready), 64'(1));
    tick();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    chk("bp_next_busy", 64'(bus.busy), 64'(1));
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("bp_next_lat", 64'(lat), 64'(LAT));
    chk("bp_next_res", {bus.rsp_hi, bus.rsp_lo}, ref_fn(2'd1, 64'hDEAD_BEEF_0BAD_F00D));
    consume();

    // Flush in the first compute state with a competing request.
    drive_req(2'd0, 64'h1111_2222_3333_4444);
    #1;
    tick();
    chk("fl_lo_busy_before", 64'(bus.busy), 64'(1));
    bus.flush = 1'b1;
    drive_req(2'd3, 64'h5555_6666_7777_8888);
    #1;
    chk("fl_lo_req_ready", 64'(bus.req_ready), 64'(0));
    tick();
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    chk("fl_lo_busy", 64'(bus.busy), 64'(0));
    chk("fl_lo_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    tick();
    chk("fl_lo_no_accept", 64'(bus.busy), 64'(0));

    // Flush in RSP with a competing request; result registers retained.
    issue(2'd3, 64'hCAFE_F00D_1234_5678, lat);
    held = ref_fn(2'd3, 64'hCAFE_F00D_1234_5678);
    chk("fl_rsp_res", {bus.rsp_hi, bus.rsp_lo}, held);
    bus.flush = 1'b1;
    drive_req(2'd0, 64'h0000_0000_0000_0001);
    #1;
    chk("fl_rsp_req_ready", 64'(bus.req_ready), 64'(0));
    tick();
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    chk("fl_rsp_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("fl_rsp_busy", 64'(bus.busy), 64'(0));
    chk("fl_rsp_kept", {bus.rsp_hi, bus.rsp_lo}, held);
    tick();
    chk("fl_rsp_no_accept", 64'(bus.busy), 64'(0));

    // Streaming with rsp_ready tied high.
    bus.rsp_ready = 1'b1;
    idx  = 0;
    got  = 0;
    cyc  = 0;
    last = 0;
    drive_req(vecs[0].op, vecs[0].x);
    while (got < 8 && cyc < 200) begin
      #1;
      acc = bus.req_valid && bus.req_ready;
      tick();
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 8) drive_req(vecs[idx].op, vecs[idx].x);
        else bus.req_valid = 1'b0;
      end
      chk("stream_busy", 64'(bus.busy), 64'(1));
      if (bus.rsp_valid) begin
        chk($sformatf("stream_res%0d", got), {bus.rsp_hi, bus.rsp_lo}, vecs[got].exp);
        if (got > 0) chk("stream_period", 64'(cyc - last), 64'(LAT));
        last = cyc;
        got++;
      end
    end
    chk("stream_count", 64'(got), 64'(8));
    chk("stream_accepts", 64'(idx), 64'(8));
    tick();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    chk("stream_idle", 64'(bus.busy), 64'(0));

    // Asynchronous reset mid-operation (HI, or CALC in the dual build).
    chk("pre_rst_rsp_nonzero", 64'({bus.rsp_hi, bus.rsp_lo} != 64'h0), 64'(1));
    drive_req(2'd1, 64'h0F0F_0F0F_F0F0_F0F0);
    #1;
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < LAT - 2; i++) tick();
    chk("mid_busy", 64'(bus.busy), 64'(1));
    chk("mid_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    rstn = 1'b0;
    #1;
    chk("arst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("arst_busy", 64'(bus.busy), 64'(0));
    chk("arst_rsp", {bus.rsp_hi, bus.rsp_lo}, 64'h0);
    rstn = 1'b1;
    tick();
    chk("arst_idle_busy", 64'(bus.busy), 64'(0));
    chk("arst_idle_ready", 64'(bus.req_ready), 64'(1));

    // Still functional after reset.
    run_op("post_rst", vecs[0].op, vecs[0].x, vecs[0].exp);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
